// File: rtl/freq_plan_regs.sv
// AXI4-Lite register block that collects a frequency plan (list of channel
// indices) into a small RAM, locks it on commit, and serves datapath lookups.
module freq_plan_regs #(
    parameter int ADDR_W = 5,
    parameter int K_W    = 14,
    parameter int DEPTH  = 128
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic [$clog2(DEPTH)-1:0] plan_raddr,
    output logic [K_W-1:0]           plan_rdata,
    output logic                     plan_valid,
    output logic [7:0]               plan_len,
    output logic [1:0]               mode
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] A_PLAN   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_MODE   = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic             aw_held_q, aw_held_d;
    logic [2:0]       awaddr_q, awaddr_d;
    logic             w_held_q, w_held_d;
    logic [K_W-1:0]   wdata_q, wdata_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             plan_valid_q, plan_valid_d;
    logic [7:0]       plan_len_q, plan_len_d;
    logic [1:0]       mode_q, mode_d;
    logic [K_W-1:0]   plan_rdata_q;
    logic             mem_we_s;
    logic [31:0]      rd_mux_s;
    logic             unused_s;

    logic [K_W-1:0] mem [DEPTH];

    assign s_axi_awready = !aw_held_q && !bvalid_q;
    assign s_axi_wready  = !w_held_q && !bvalid_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign plan_rdata    = plan_rdata_q;
    assign plan_valid    = plan_valid_q;
    assign plan_len      = plan_len_q;
    assign mode          = mode_q;

    // Strobes and the byte-lane address bits carry no meaning here.
    assign unused_s = ^{s_axi_wstrb, s_axi_wdata[31:K_W], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Register read decode, sampled into rdata on AR acceptance.
    always_comb begin
        rd_mux_s = 32'd0;
        case (s_axi_araddr[4:2])
            A_PLAN:   rd_mux_s = 32'(wr_ptr_q);
            A_CTRL:   rd_mux_s = {31'd0, plan_valid_q};
            A_STATUS: rd_mux_s = {22'd0, overflow_q, plan_valid_q, 8'(count_q)};
            A_MODE:   rd_mux_s = {30'd0, mode_q};
            default:  rd_mux_s = 32'd0;
        endcase
    end

    // Next-state for the AXI channels and the plan bookkeeping registers.
    always_comb begin
        aw_held_d    = aw_held_q;
        awaddr_d     = awaddr_q;
        w_held_d     = w_held_q;
        wdata_d      = wdata_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        plan_valid_d = plan_valid_q;
        plan_len_d   = plan_len_q;
        mode_d       = mode_q;
        mem_we_s     = 1'b0;

        if (s_axi_awvalid && s_axi_awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr[4:2];
        end else begin
            aw_held_d = aw_held_q;
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata[K_W-1:0];
        end else begin
            w_held_d = w_held_q;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // Both halves present: bvalid is necessarily low here, so the write fires now.
        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            case (awaddr_q)
                A_PLAN: begin
                    if (plan_valid_q) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        mem_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == CNT_W'(DEPTH)) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                A_CTRL: begin
                    if (wdata_q[1]) begin
                        wr_ptr_d     = '0;
                        count_d      = '0;
                        overflow_d   = 1'b0;
                        plan_valid_d = 1'b0;
                        plan_len_d   = 8'd0;
                    end else if (wdata_q[0]) begin
                        if (count_q == '0) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            plan_valid_d = 1'b1;
                            plan_len_d   = 8'(count_q);
                        end
                    end else begin
                        plan_valid_d = plan_valid_q;
                    end
                end
                A_MODE: begin
                    mode_d = wdata_q[1:0];
                end
                default: begin
                    bresp_d = RESP_OKAY;
                end
            endcase
        end else begin
            bresp_d = bresp_q;
        end

        if (!rvalid_q && s_axi_arvalid) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux_s;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State flops with asynchronous reset.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            aw_held_q    <= 1'b0;
            awaddr_q     <= 3'd0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            plan_valid_q <= 1'b0;
            plan_len_q   <= 8'd0;
            mode_q       <= 2'd0;
            plan_rdata_q <= '0;
        end else begin
            aw_held_q    <= aw_held_d;
            awaddr_q     <= awaddr_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            plan_valid_q <= plan_valid_d;
            plan_len_q   <= plan_len_d;
            mode_q       <= mode_d;
            plan_rdata_q <= mem[plan_raddr];
        end
    end

    // Plan RAM: no reset; a same-entry lookup in the write cycle sees old data.
    always_ff @(posedge clk_100MHz) begin
        if (mem_we_s) begin
            mem[wr_ptr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_freq_plan_regs.sv
// Randomized self-checking bench for freq_plan_regs against a behavioural plan model.
module tb_freq_plan_regs;

    localparam int DEPTH = 128;
    localparam int K_W   = 14;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic [4:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [6:0]  plan_raddr;
    logic [13:0] plan_rdata;
    logic        plan_valid;
    logic [7:0]  plan_len;
    logic [1:0]  mode;

    always #5 clk_100MHz = ~clk_100MHz;

    freq_plan_regs #(.ADDR_W(5), .K_W(K_W), .DEPTH(DEPTH)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .plan_raddr(plan_raddr), .plan_rdata(plan_rdata), .plan_valid(plan_valid),
        .plan_len(plan_len), .mode(mode)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the plan table and registers.
    logic [13:0] m_mem [DEPTH];
    bit          m_written [DEPTH];
    int          m_ptr, m_count, m_len, m_mode;
    bit          m_ovf, m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_len = 0; m_mode = 0; m_ovf = 0; m_valid = 0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (a[4:2])
            3'd0: begin
                if (m_valid) resp = 2'b10;
                else begin
                    m_mem[m_ptr] = d[13:0];
                    m_written[m_ptr] = 1'b1;
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_count == DEPTH) m_ovf = 1'b1;
                    else m_count = m_count + 1;
                end
            end
            3'd1: begin
                if (d[1]) begin
                    m_ptr = 0; m_count = 0; m_ovf = 0; m_valid = 0; m_len = 0;
                end else if (d[0]) begin
                    if (m_count == 0) resp = 2'b10;
                    else begin m_valid = 1'b1; m_len = m_count; end
                end
            end
            3'd4: m_mode = int'(d[1:0]);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0: return 32'(m_ptr);
            3'd1: return 32'(m_valid);
            3'd3: return 32'((int'(m_ovf) << 9) | (int'(m_valid) << 8) | (m_count % 256));
            3'd4: return 32'(m_mode);
            default: return 32'd0;
        endcase
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit aw_go, w_go, b_go, got;
        logic [1:0] br;
        got = 1'b0; resp = 2'b11;
        @(negedge clk_100MHz);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = 4'($urandom);
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            b_go  = s_axi_bvalid && s_axi_bready;
            br    = s_axi_bresp;
            @(negedge clk_100MHz);
            if (aw_go) s_axi_awvalid = 1'b0;
            if (w_go) s_axi_wvalid = 1'b0;
            if (b_go) begin resp = br; got = 1'b1; s_axi_bready = 1'b0; end
        end
        if (!got) begin
            check("wr_timeout", 32'd0, 32'd1);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        bit ar_go, r_go, got;
        logic [31:0] rd;
        got = 1'b0; d = 32'd0;
        @(negedge clk_100MHz);
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            ar_go = s_axi_arvalid && s_axi_arready;
            r_go  = s_axi_rvalid && s_axi_rready;
            rd    = s_axi_rdata;
            @(negedge clk_100MHz);
            if (ar_go) s_axi_arvalid = 1'b0;
            if (r_go) begin d = rd; got = 1'b1; s_axi_rready = 1'b0; end
        end
        if (!got) begin
            check("rd_timeout", 32'd0, 32'd1);
            s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        end
    endtask

    // DUT write plus model update; response checked against the model.
    task automatic do_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        logic [1:0] r_dut, r_mod;
        axi_write(a, d, r_dut);
        model_write(a, d, r_mod);
        check(tag, 32'(r_dut), 32'(r_mod));
    endtask

    task automatic do_read(input string tag, input logic [4:0] a);
        logic [31:0] rd;
        axi_read(a, rd);
        check(tag, rd, model_read(a));
    endtask

    task automatic lookup(input string tag, input int idx, input logic [31:0] exp);
        @(negedge clk_100MHz);
        plan_raddr = 7'(idx);
        @(negedge clk_100MHz);
        check(tag, 32'(plan_rdata), exp);
    endtask

    logic [31:0] rd;
    logic [1:0]  resp;
    logic [4:0]  ra;
    int          op, idx;

    initial begin
        reset = 1'b1;
        s_axi_awaddr = 5'd0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 5'd0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; plan_raddr = 7'd0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("rst_outputs", {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, plan_valid, plan_len, mode},
              32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_plan_rdata", 32'(plan_rdata), 32'd0);
        reset = 1'b0;
        @(negedge clk_100MHz);
        check("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

        // Build a three-entry plan and commit it.
        do_write("plan_w0", 5'h00, 32'h0005);
        do_write("plan_w1", 5'h00, 32'h1FFF);
        do_write("plan_w2", 5'h00, 32'h0010);
        do_write("commit", 5'h04, 32'h1);
        axi_read(5'h0C, rd);
        check("status_commit", rd, 32'h103);
        check("plan_len_3", 32'(plan_len), 32'd3);
        lookup("lookup_1", 1, 32'h1FFF);

        // Writes to a locked plan are refused.
        axi_write(5'h00, 32'h0AAA, resp);
        model_write(5'h00, 32'h0AAA, resp);
        check("locked_bresp", 32'(resp), 32'd2);
        axi_read(5'h0C, rd);
        check("locked_status", rd, 32'h103);
        lookup("locked_entry0", 0, 32'h0005);

        // Mode survives a clear+commit CTRL write.
        do_write("mode_w", 5'h10, 32'h2);
        check("mode_out", 32'(mode), 32'd2);
        axi_read(5'h10, rd);
        check("mode_rb", rd, 32'd2);
        do_write("ctrl3", 5'h04, 32'h3);
        check("ctrl3_valid", 32'(plan_valid), 32'd0);
        axi_read(5'h0C, rd);
        check("ctrl3_status", rd, 32'd0);
        check("ctrl3_mode", 32'(mode), 32'd2);

        // AW three cycles ahead of W, response held off for five cycles.
        @(negedge clk_100MHz);
        s_axi_awaddr = 5'h00; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
        @(negedge clk_100MHz);
        s_axi_awvalid = 1'b0;
        check("skew_awready", 32'(s_axi_awready), 32'd0);
        repeat (2) begin
            @(negedge clk_100MHz);
            check("skew_nob", 32'(s_axi_bvalid), 32'd0);
        end
        s_axi_wdata = 32'h0123; s_axi_wvalid = 1'b1;
        @(negedge clk_100MHz);
        s_axi_wvalid = 1'b0;
        repeat (5) begin
            @(negedge clk_100MHz);
            check("skew_bhold", {29'd0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 32'd4);
        end
        s_axi_bready = 1'b1;
        @(negedge clk_100MHz);
        s_axi_bready = 1'b0;
        check("skew_bdone", {29'd0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 32'd3);
        model_write(5'h00, 32'h0123, resp);
        do_read("skew_status", 5'h0C);
        check("skew_single", model_read(5'h0C), 32'd1);

        // Commit of an empty plan is refused.
        do_write("clear", 5'h04, 32'h2);
        axi_write(5'h04, 32'h1, resp);
        model_write(5'h04, 32'h1, resp);
        check("empty_commit", 32'(resp), 32'd2);
        check("empty_valid", 32'(plan_valid), 32'd0);

        // Overfill: 129 writes wrap and set overflow.
        for (int i = 0; i < DEPTH + 1; i++) do_write("fill", 5'h00, 32'(i));
        axi_read(5'h0C, rd);
        check("fill_status", rd, 32'h280);
        lookup("fill_entry0", 0, 32'd128);
        lookup("fill_entry5", 5, 32'd5);

        // Reset in the middle of a write drops it.
        @(negedge clk_100MHz);
        s_axi_awaddr = 5'h10; s_axi_awvalid = 1'b1;
        @(negedge clk_100MHz);
        s_axi_awvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        model_reset();
        @(negedge clk_100MHz);
        check("midrst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        repeat (3) @(negedge clk_100MHz);
        check("midrst_nob", 32'(s_axi_bvalid), 32'd0);
        do_read("midrst_status", 5'h0C);

        // Randomized mix of register traffic and lookups.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 11);
            if (op <= 4) begin
                do_write("rnd_plan", 5'h00 | 5'($urandom_range(0, 3)), $urandom);
            end else if (op == 5) begin
                do_write("rnd_ctrl", 5'h04, (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h1)
                         | ($urandom & 32'hFFFF_FFFC));
            end else if (op == 6) begin
                do_write("rnd_mode", 5'h10, $urandom);
            end else if (op == 7) begin
                ra = 5'({$urandom_range(5, 7)} << 2);
                if ($urandom_range(0, 1) == 1) ra = 5'h08;
                do_write("rnd_unmapped", ra, $urandom);
            end else if (op <= 9) begin
                ra = 5'($urandom_range(0, 7) << 2);
                do_read("rnd_read", ra);
            end else begin
                idx = $urandom_range(0, DEPTH - 1);
                if (m_written[idx]) lookup("rnd_lookup", idx, 32'(m_mem[idx]));
            end
            if (op <= 7) begin
                check("rnd_outs", {22'd0, plan_valid, plan_len, mode},
                      32'((int'(m_valid) << 10) | ((m_len % 256) << 2) | m_mode));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: observed 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule
